// File: rtl/ram_dp_be_if.sv
// Port bundle for ram_dp_be: clear control, port A read/write, port B read.
// The RAM owns the slave side; the master side drives commands and reads data back.
interface ram_dp_be_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                  clr;
  logic                  busy;
  logic                  err;
  logic                  a_cen;
  logic                  a_wen;
  logic [DATA_W/8-1:0]   a_be;
  logic [ADDR_W-1:0]     a_addr;
  logic [DATA_W-1:0]     a_din;
  logic [DATA_W-1:0]     a_dout;
  logic                  b_cen;
  logic [ADDR_W-1:0]     b_addr;
  logic [DATA_W-1:0]     b_dout;

  modport master (
    output clr, a_cen, a_wen, a_be, a_addr, a_din, b_cen, b_addr,
    input  busy, err, a_dout, b_dout
  );

  modport slave (
    input  clr, a_cen, a_wen, a_be, a_addr, a_din, b_cen, b_addr,
    output busy, err, a_dout, b_dout
  );
endinterface

// File: rtl/ram_dp_be.sv
// Dual-port RAM (A: byte-enabled read/write, B: read) with a zeroing sweep after reset or clr.
// Reads return one cycle later; during the sweep both ports are locked out and err flags access.
module ram_dp_be #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int RDW_MODE = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  ram_dp_be_if.slave  bus
);
  localparam int                NBYTE = DATA_W / 8;
  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              busy_c;
  logic              a_wr;
  logic [DATA_W-1:0] a_merged;
  logic [DATA_W-1:0] b_word;
  logic [DATA_W-1:0] a_dout_q, b_dout_q;
  logic              err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= CLEAR;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (ptr == LAST) state_nxt = IDLE;
      IDLE:    if (bus.clr)     state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    busy_c = (state == CLEAR);
  end

  // Pointer parks on the last word once the sweep ends and is rearmed by clr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                ptr <= '0;
    else if (busy_c)             ptr <= (ptr == LAST) ? ptr : ptr + 1'b1;
    else if (bus.clr)            ptr <= '0;
  end

  assign a_wr = ~busy_c & bus.a_cen & bus.a_wen;

  always_comb begin
    a_merged = mem[bus.a_addr];
    for (int i = 0; i < NBYTE; i++) begin
      if (bus.a_be[i]) a_merged[8*i +: 8] = bus.a_din[8*i +: 8];
    end
  end

  // Same-address collision: forward the merged word to B only in new-data mode.
  always_comb begin
    b_word = mem[bus.b_addr];
    if (RDW_MODE != 0 && a_wr && bus.a_addr == bus.b_addr) b_word = a_merged;
  end

  always_ff @(posedge clk) begin
    if (busy_c)    mem[ptr]        <= '0;
    else if (a_wr) mem[bus.a_addr] <= a_merged;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_dout_q <= '0;
      b_dout_q <= '0;
      err_q    <= 1'b0;
    end else if (busy_c) begin
      a_dout_q <= '0;
      b_dout_q <= '0;
      err_q    <= bus.a_cen | bus.b_cen;
    end else begin
      a_dout_q <= (bus.a_cen && !bus.a_wen) ? mem[bus.a_addr] : '0;
      b_dout_q <= bus.b_cen ? b_word : '0;
      err_q    <= 1'b0;
    end
  end

  assign bus.busy   = busy_c;
  assign bus.a_dout = a_dout_q;
  assign bus.b_dout = b_dout_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_ram_dp_be.sv
// Directed bench for ram_dp_be: two 32x32 instances (old/new read-during-write) and a 64x8 instance.
// Inputs change 1 time unit after posedge; registered outputs are sampled at the same point.
module tb_ram_dp_be;
  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  ram_dp_be_if #(.DATA_W(32), .ADDR_W(5)) if0 ();
  ram_dp_be_if #(.DATA_W(32), .ADDR_W(5)) if1 ();
  ram_dp_be_if #(.DATA_W(64), .ADDR_W(3)) if2 ();

  ram_dp_be #(.DATA_W(32), .ADDR_W(5), .RDW_MODE(0)) u_rdw0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  ram_dp_be #(.DATA_W(32), .ADDR_W(5), .RDW_MODE(1)) u_rdw1 (.clk(clk), .reset_n(reset_n), .bus(if1));
  ram_dp_be #(.DATA_W(64), .ADDR_W(3), .RDW_MODE(0)) u_w64  (.clk(clk), .reset_n(reset_n), .bus(if2));

  int n_chk = 0;
  int n_err = 0;
  int cnt0, cnt1, cnt2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Port A and B stimulus goes to both 32-bit instances identically.
  task automatic drv_a(input logic cen, input logic wen, input logic [3:0] be,
                       input logic [4:0] addr, input logic [31:0] din);
    if0.a_cen = cen;  if1.a_cen = cen;
    if0.a_wen = wen;  if1.a_wen = wen;
    if0.a_be = be;    if1.a_be = be;
    if0.a_addr = addr; if1.a_addr = addr;
    if0.a_din = din;  if1.a_din = din;
  endtask

  task automatic drv_b(input logic cen, input logic [4:0] addr);
    if0.b_cen = cen;   if1.b_cen = cen;
    if0.b_addr = addr; if1.b_addr = addr;
  endtask

  task automatic drv_clr(input logic v);
    if0.clr = v;
    if1.clr = v;
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      drv_a(1'b1, 1'b0, 4'h0, 5'(i), 32'h0);
      drv_b(1'b1, 5'(31 - i));
      step();
      check($sformatf("%s_a[%0d]", tag, i), 64'(if0.a_dout), 64'h0);
      check($sformatf("%s_b[%0d]", tag, 31 - i), 64'(if0.b_dout), 64'h0);
      check($sformatf("%s_b1[%0d]", tag, 31 - i), 64'(if1.b_dout), 64'h0);
    end
    drv_a(1'b0, 1'b0, 4'h0, 5'd0, 32'h0);
    drv_b(1'b0, 5'd0);
  endtask

  task automatic count_sweep();
    cnt0 = 0; cnt1 = 0; cnt2 = 0;
    for (int i = 0; i < 40; i++) begin
      cnt0 += int'(if0.busy);
      cnt1 += int'(if1.busy);
      cnt2 += int'(if2.busy);
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    drv_a(1'b0, 1'b0, 4'h0, 5'd0, 32'h0);
    drv_b(1'b0, 5'd0);
    drv_clr(1'b0);
    if2.clr = 1'b0; if2.a_cen = 1'b0; if2.a_wen = 1'b0; if2.a_be = '0;
    if2.a_addr = '0; if2.a_din = '0; if2.b_cen = 1'b0; if2.b_addr = '0;

    // Reset state
    #1;
    check("rst_busy", 64'(if0.busy), 64'h1);
    check("rst_a_dout", 64'(if0.a_dout), 64'h0);
    check("rst_b_dout", 64'(if0.b_dout), 64'h0);
    check("rst_err", 64'(if0.err), 64'h0);
    check("rst_busy_64", 64'(if2.busy), 64'h1);

    step();
    reset_n = 1'b1;
    count_sweep();
    check("sweep_len_rdw0", 64'(cnt0), 64'd32);
    check("sweep_len_rdw1", 64'(cnt1), 64'd32);
    check("sweep_len_64", 64'(cnt2), 64'd8);
    read_all_zero("init");
    check("idle_err", 64'(if0.err), 64'h0);

    // Byte-enable merge on port A
    drv_a(1'b1, 1'b1, 4'hF, 5'd5, 32'hAABBCCDD); step();
    drv_a(1'b1, 1'b0, 4'h0, 5'd5, 32'h0);        step();
    check("be_full_rd", 64'(if0.a_dout), 64'hAABBCCDD);
    drv_a(1'b1, 1'b1, 4'b0101, 5'd5, 32'h11223344); step();
    check("wr_dout_zero", 64'(if0.a_dout), 64'h0);
    drv_a(1'b1, 1'b1, 4'b0000, 5'd5, 32'hFFFFFFFF); step();
    drv_a(1'b1, 1'b0, 4'h0, 5'd5, 32'h0);
    drv_b(1'b1, 5'd5);
    step();
    check("be_merge_a", 64'(if0.a_dout), 64'hAA22CC44);
    check("be_merge_b", 64'(if0.b_dout), 64'hAA22CC44);
    drv_a(1'b0, 1'b0, 4'h0, 5'd5, 32'h0);
    drv_b(1'b0, 5'd5);
    step();
    check("cen0_a", 64'(if0.a_dout), 64'h0);
    check("cen0_b", 64'(if0.b_dout), 64'h0);

    // Read-during-write collision on address 9
    drv_a(1'b1, 1'b1, 4'hF, 5'd9, 32'hDEADBEEF);
    drv_b(1'b1, 5'd9);
    step();
    check("rdw_old_b", 64'(if0.b_dout), 64'h0);
    check("rdw_new_b", 64'(if1.b_dout), 64'hDEADBEEF);
    drv_a(1'b1, 1'b0, 4'h0, 5'd9, 32'h0);
    step();
    check("rdw_after_a", 64'(if0.a_dout), 64'hDEADBEEF);
    check("rdw_after_b0", 64'(if0.b_dout), 64'hDEADBEEF);
    check("rdw_after_b1", 64'(if1.b_dout), 64'hDEADBEEF);
    drv_b(1'b0, 5'd0);

    // Fill, then clear on request with lockout and an ignored second clr
    for (int i = 0; i < 32; i++) begin
      drv_a(1'b1, 1'b1, 4'hF, 5'(i), {8'(i), 8'hA5, 8'(i), 8'h5A});
      step();
    end
    drv_a(1'b1, 1'b0, 4'h0, 5'd3, 32'h0); step();
    check("fill_rd3", 64'(if0.a_dout), 64'h03A5035A);
    drv_a(1'b1, 1'b0, 4'h0, 5'd20, 32'h0); step();
    check("fill_rd20", 64'(if0.a_dout), 64'h14A5145A);
    drv_a(1'b0, 1'b0, 4'h0, 5'd0, 32'h0);
    drv_clr(1'b1); step();
    drv_clr(1'b0);
    cnt0 = 0; cnt1 = 0;
    for (int j = 0; j < 60; j++) begin
      cnt0 += int'(if0.busy);
      cnt1 += int'(if1.busy);
      if (j == 10) drv_a(1'b1, 1'b1, 4'hF, 5'd3, 32'hCAFEF00D);
      if (j == 11) begin
        check("busy_wr_err", 64'(if0.err), 64'h1);
        check("busy_a_dout", 64'(if0.a_dout), 64'h0);
        drv_a(1'b0, 1'b0, 4'h0, 5'd0, 32'h0);
      end
      if (j == 12) check("busy_err_pulse", 64'(if0.err), 64'h0);
      if (j == 15) drv_clr(1'b1);
      if (j == 16) drv_clr(1'b0);
      step();
    end
    check("clr_sweep_len", 64'(cnt0), 64'd32);
    check("clr_sweep_len1", 64'(cnt1), 64'd32);
    read_all_zero("clr");

    // Reset in the middle of a sweep (pointer at 17)
    drv_clr(1'b1); step();
    drv_clr(1'b0);
    for (int j = 0; j < 17; j++) begin
      if (j == 16) drv_a(1'b1, 1'b0, 4'h0, 5'd0, 32'h0);
      step();
    end
    check("mid_sweep_err", 64'(if0.err), 64'h1);
    drv_a(1'b0, 1'b0, 4'h0, 5'd0, 32'h0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_err", 64'(if0.err), 64'h0);
    check("mid_rst_busy", 64'(if0.busy), 64'h1);
    check("mid_rst_a", 64'(if0.a_dout), 64'h0);
    check("mid_rst_b", 64'(if0.b_dout), 64'h0);
    step(); step();
    reset_n = 1'b1;
    count_sweep();
    check("rst_sweep_len", 64'(cnt0), 64'd32);
    check("rst_sweep_len_64", 64'(cnt2), 64'd8);
    read_all_zero("rst");

    // 64-bit, 8-deep instance: merge and short sweep
    if2.a_cen = 1'b1; if2.a_wen = 1'b1; if2.a_be = 8'hFF; if2.a_addr = 3'd2;
    if2.a_din = 64'h0102030405060708;
    step();
    if2.a_be = 8'b1010_0101; if2.a_din = 64'hA0A1A2A3A4A5A6A7;
    step();
    if2.a_cen = 1'b0; if2.b_cen = 1'b1; if2.b_addr = 3'd2;
    step();
    check("w64_merge_b", if2.b_dout, 64'hA002A20405A507A7);
    if2.a_cen = 1'b1; if2.a_wen = 1'b0; if2.b_cen = 1'b0;
    step();
    check("w64_merge_a", if2.a_dout, 64'hA002A20405A507A7);
    check("w64_b_off", if2.b_dout, 64'h0);
    if2.a_cen = 1'b0; if2.clr = 1'b1;
    step();
    if2.clr = 1'b0;
    cnt2 = 0;
    for (int j = 0; j < 20; j++) begin
      cnt2 += int'(if2.busy);
      step();
    end
    check("w64_sweep_len", 64'(cnt2), 64'd8);
    if2.b_cen = 1'b1; if2.b_addr = 3'd2;
    step();
    check("w64_cleared", if2.b_dout, 64'h0);
    if2.b_cen = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
